// File: rtl/input_debouncer_pkg.sv
// Shared types and defaults for the input debouncer slice.
package input_debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } deb_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_SYNC_STAGES     = 2;

endpackage

// File: rtl/sync_nff.sv
// N-flop level synchronizer with asynchronous active-low reset to 0.
module sync_nff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronizes a bouncing level input and accepts a change only after
// DEBOUNCE_CYCLES consecutive agreeing samples; counts rejected candidates.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din_raw,
  input  logic       en,
  output logic       d_clean,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic       busy,
  output logic [7:0] glitch_cnt
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_s;
  deb_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_d_clean, w_d_clean_nxt;
  logic             r_rise, w_rise_nxt;
  logic             r_fall, w_fall_nxt;
  logic [7:0]       r_glitch, w_glitch_nxt;
  logic             w_reject;

  sync_nff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (din_raw),
    .q     (w_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= STABLE_LOW;
      r_cnt     <= '0;
      r_d_clean <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_glitch  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_d_clean <= w_d_clean_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_glitch  <= w_glitch_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_d_clean_nxt = r_d_clean;
    w_rise_nxt    = 1'b0;
    w_fall_nxt    = 1'b0;
    w_reject      = 1'b0;
    case (r_state)
      STABLE_LOW: begin
        if (en && w_s) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        // Dropping enable abandons the candidate silently; it is not a glitch.
        if (!en) begin
          w_state_nxt = STABLE_LOW;
          w_cnt_nxt   = '0;
        end else if (w_s) begin
          if (r_cnt == LP_CNT_LAST) begin
            w_state_nxt   = STABLE_HIGH;
            w_cnt_nxt     = '0;
            w_d_clean_nxt = 1'b1;
            w_rise_nxt    = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_state_nxt = STABLE_LOW;
          w_cnt_nxt   = '0;
          w_reject    = 1'b1;
        end
      end
      STABLE_HIGH: begin
        if (en && !w_s) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (!en) begin
          w_state_nxt = STABLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (!w_s) begin
          if (r_cnt == LP_CNT_LAST) begin
            w_state_nxt   = STABLE_LOW;
            w_cnt_nxt     = '0;
            w_d_clean_nxt = 1'b0;
            w_fall_nxt    = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_state_nxt = STABLE_HIGH;
          w_cnt_nxt   = '0;
          w_reject    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = STABLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_glitch_nxt = r_glitch;
    if (w_reject && (r_glitch != 8'hFF)) begin
      w_glitch_nxt = r_glitch + 8'd1;
    end
  end

  assign d_clean    = r_d_clean;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign busy       = (r_state == WAIT_HIGH) || (r_state == WAIT_LOW);
  assign glitch_cnt = r_glitch;

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench: driver pushes model predictions, monitor compares each cycle.
module tb_input_debouncer;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;

  typedef struct packed {
    logic       d;
    logic       r;
    logic       f;
    logic       b;
    logic [7:0] g;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic       din_raw;
  logic       en;
  logic       d_clean;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       busy;
  logic [7:0] glitch_cnt;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   started = 0;
  obs_t exp_q[$];

  // Reference model: delayed-sample queue plus "run length of disagreement".
  bit pipe[$];
  int m_clean, m_run, m_glitch;

  input_debouncer #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_raw    (din_raw),
    .en         (en),
    .d_clean    (d_clean),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy),
    .glitch_cnt (glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t model_step(input bit d_in, input bit e_in, input bit r_in);
    obs_t o;
    bit   s;
    bit   rise;
    bit   fall;
    rise = 1'b0;
    fall = 1'b0;
    if (!r_in) begin
      pipe.delete();
      for (int i = 0; i < SYNC; i++) pipe.push_back(1'b0);
      m_clean  = 0;
      m_run    = 0;
      m_glitch = 0;
    end else begin
      s = pipe.pop_back();
      pipe.push_front(d_in);
      if (!e_in) begin
        m_run = 0;
      end else if (int'(s) != m_clean) begin
        m_run++;
        if (m_run == DEB) begin
          m_clean = int'(s);
          rise    = s;
          fall    = !s;
          m_run   = 0;
        end
      end else begin
        if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end
    end
    o.d = (m_clean != 0);
    o.r = rise;
    o.f = fall;
    o.b = (m_run > 0);
    o.g = 8'(m_glitch);
    return o;
  endfunction

  task automatic step(input bit d_in, input bit e_in, input bit r_in);
    bit   prev_rst;
    obs_t act;
    @(negedge clk);
    prev_rst = rst_n;
    din_raw  = d_in;
    en       = e_in;
    rst_n    = r_in;
    if (prev_rst && !r_in) begin
      #1;
      act = {d_clean, rise_pulse, fall_pulse, busy, glitch_cnt};
      checks++;
      if (act !== '0) begin
        errors++;
        $display("FAIL async_reset t=%0t got=%h want=%h", $time, act, 12'h000);
      end
    end
    exp_q.push_back(model_step(d_in, e_in, r_in));
    started = 1'b1;
  endtask

  initial begin : monitor
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      a = {d_clean, rise_pulse, fall_pulse, busy, glitch_cnt};
      if (exp_q.size() == 0) begin
        if (started) begin
          checks++;
          errors++;
          $display("FAIL missing_expect cycle=%0d got=%h want=<queued value>", cyc, a);
        end
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_obs cycle=%0d got d=%b r=%b f=%b b=%b g=%0d want d=%b r=%b f=%b b=%b g=%0d",
                   cyc, a.d, a.r, a.f, a.b, a.g, e.d, e.r, e.f, e.b, e.g);
        end
      end
    end
  end

  initial begin : driver
    bit d;
    din_raw = 1'b0;
    en      = 1'b1;
    rst_n   = 1'b0;
    repeat (3) step(0, 1, 0);
    // Rise qualification, then fall qualification.
    repeat (10) step(1, 1, 1);
    repeat (10) step(0, 1, 1);
    // Three-cycle glitch from STABLE_LOW.
    repeat (3) step(1, 1, 1);
    repeat (8) step(0, 1, 1);
    // Enable dropped mid-qualification.
    repeat (3) step(1, 1, 1);
    step(1, 0, 1);
    repeat (8) step(1, 1, 1);
    repeat (10) step(0, 1, 1);
    // Reset mid-qualification with input held high.
    repeat (4) step(1, 1, 1);
    repeat (2) step(1, 1, 0);
    repeat (10) step(1, 1, 1);
    repeat (10) step(0, 1, 1);
    // Glitch counter saturation.
    repeat (300) begin
      repeat (2) step(1, 1, 1);
      repeat (4) step(0, 1, 1);
    end
    @(posedge clk);
    #2;
    checks++;
    if (glitch_cnt !== 8'd255) begin
      errors++;
      $display("FAIL glitch_sat got=%0d want=255", glitch_cnt);
    end
    checks++;
    if (d_clean !== 1'b0) begin
      errors++;
      $display("FAIL glitch_dclean got=%b want=0", d_clean);
    end
    // Random runs with occasional enable drops and resets.
    repeat (2) step(0, 1, 0);
    d = 1'b0;
    repeat (400) begin
      d = ~d;
      repeat ($urandom_range(1, 8)) begin
        step(d, ($urandom_range(0, 9) != 0), ($urandom_range(0, 199) != 0));
      end
    end
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
